// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from ID/EX/memories and the stall/flush controls back.
interface pipe_hazard_ctrl_if #(parameter int REG_AW = 3, parameter int CNT_W = 16);
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
  logic id_rs_vld, id_rt_vld, ex_wr_en, ex_mem_rd, br_taken, imem_stall, dmem_stall;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
  logic [CNT_W-1:0] stall_cnt, redir_cnt;
  modport master (
    output id_rs, id_rs_vld, id_rt, id_rt_vld, ex_rd, ex_wr_en, ex_mem_rd,
           br_taken, imem_stall, dmem_stall,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           stall_cnt, redir_cnt
  );
  modport slave (
    input  id_rs, id_rs_vld, id_rt, id_rt_vld, ex_rd, ex_wr_en, ex_mem_rd,
           br_taken, imem_stall, dmem_stall,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           stall_cnt, redir_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler for the pipeline front end with perf counters.
module pipe_hazard_ctrl #(parameter int REG_AW = 3, parameter int CNT_W = 16) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave h
);
  typedef enum logic [1:0] {RUN, SQUASH} state_t;
  state_t state, state_nx;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [CNT_W-1:0] stall_cnt, redir_cnt;
  logic lu_haz, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, redir;
  assign rs = h.id_rs;
  assign rt = h.id_rt;
  assign rd = h.ex_rd;
  assign lu_haz = h.ex_mem_rd & h.ex_wr_en & ((h.id_rs_vld & rs == rd) | (h.id_rt_vld & rt == rd));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    pc_stall = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_stall = 1'b0;
    redir = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state == SQUASH) begin
      // Wrong-path word still in flight: keep PC and IF_ID quiet until fetch goes idle
      pc_stall = 1'b1;
      if_id_flush = 1'b1;
      id_ex_stall = h.dmem_stall;
      ex_mem_stall = h.dmem_stall;
      id_ex_flush = !h.dmem_stall && lu_haz;
      state_nx = h.imem_stall ? SQUASH : RUN;
    end else if (h.dmem_stall) begin
      pc_stall = 1'b1;
      if_id_stall = 1'b1;
      id_ex_stall = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (h.br_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      redir = 1'b1;
      state_nx = h.imem_stall ? SQUASH : RUN;
    end else if (lu_haz) begin
      pc_stall = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else if (h.imem_stall) begin
      pc_stall = 1'b1;
      if_id_flush = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      if (pc_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (redir && redir_cnt != '1) redir_cnt <= redir_cnt + 1'b1;
    end
  assign h.pc_stall = pc_stall;
  assign h.if_id_stall = if_id_stall;
  assign h.if_id_flush = if_id_flush;
  assign h.id_ex_stall = id_ex_stall;
  assign h.id_ex_flush = id_ex_flush;
  assign h.ex_mem_stall = ex_mem_stall;
  assign h.stall_cnt = stall_cnt;
  assign h.redir_cnt = redir_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios then random traffic checked against a rule-level model.
module tb_pipe_hazard_ctrl;
  localparam int REG_AW = 3;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  bit m_squash = 0;
  int m_stall = 0;
  int m_redir = 0;
  pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) h ();
  pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .h(h.slave));
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(bit [2:0] rs, bit rsv, bit [2:0] rt, bit rtv, bit [2:0] rd,
                        bit wr, bit ld, bit br, bit im, bit dm);
    h.id_rs = rs; h.id_rs_vld = rsv; h.id_rt = rt; h.id_rt_vld = rtv;
    h.ex_rd = rd; h.ex_wr_en = wr; h.ex_mem_rd = ld;
    h.br_taken = br; h.imem_stall = im; h.dmem_stall = dm;
  endtask

  // One cycle: compare combinational outputs mid-cycle, then advance the model at the edge.
  task automatic step(string tag);
    bit haz;
    bit [5:0] e;
    int pcs;
    #1;
    if (rst) begin
      m_squash = 0; m_stall = 0; m_redir = 0;
    end
    haz = h.ex_mem_rd && h.ex_wr_en &&
          ((h.id_rs_vld && h.id_rs == h.ex_rd) || (h.id_rt_vld && h.id_rt == h.ex_rd));
    // bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall
    if (rst) e = 6'b001010;
    else if (m_squash) e = h.dmem_stall ? 6'b101101 : (haz ? 6'b101010 : 6'b101000);
    else if (h.dmem_stall) e = 6'b110101;
    else if (h.br_taken) e = 6'b001010;
    else if (haz) e = 6'b110010;
    else if (h.imem_stall) e = 6'b101000;
    else e = 6'b000000;
    chk({tag, ".ctl"}, {26'd0, h.pc_stall, h.if_id_stall, h.if_id_flush,
                        h.id_ex_stall, h.id_ex_flush, h.ex_mem_stall}, {26'd0, e});
    chk({tag, ".stall_cnt"}, {28'd0, h.stall_cnt}, m_stall);
    chk({tag, ".redir_cnt"}, {28'd0, h.redir_cnt}, m_redir);
    pcs = e[5];
    @(posedge clk);
    if (!rst) begin
      if (pcs != 0) m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
      if (!m_squash && !h.dmem_stall && h.br_taken) begin
        m_redir = (m_redir + 1 > CMAX) ? CMAX : m_redir + 1;
        m_squash = h.imem_stall;
      end else if (m_squash) m_squash = h.imem_stall;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("T1.rst0");
    step("T1.rst1");
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();
    chk("T1.pc_stall", {31'd0, h.pc_stall}, 0);
    // T2 load-use: one bubble, then the load has moved on
    set_in(3, 1, 5, 1, 3, 1, 1, 0, 0, 0);
    step("T2.haz");
    set_in(3, 1, 5, 1, 3, 1, 0, 0, 0, 0);
    step("T2.after");
    chk("T2.stall_cnt_lit", {28'd0, h.stall_cnt}, 1);
    // T3 redirect with fetch idle
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("T3.br");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("T3.after");
    chk("T3.redir_lit", {28'd0, h.redir_cnt}, 1);
    // T4 redirect during busy fetch: SQUASH until imem goes idle
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("T4.br");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("T4.sq");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("T4.release");
    step("T4.run");
    chk("T4.stall_lit", {28'd0, h.stall_cnt}, 4);
    // T5 priority: dmem freeze beats redirect and load-use
    do_reset();
    set_in(2, 1, 0, 0, 2, 1, 1, 1, 0, 1);
    step("T5.freeze");
    step("T5.freeze2");
    set_in(2, 1, 0, 0, 2, 1, 1, 1, 0, 0);
    step("T5.redir");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("T5.after");
    // T6 saturation
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step("T6.sat");
    chk("T6.sat_lit", {28'd0, h.stall_cnt}, 15);
    // Random traffic, including resets landing mid-SQUASH or mid-stall
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 3);
      set_in(3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
             3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) < 4),
             1'($urandom_range(0, 4) == 0));
      step("RND");
      if (!rst) begin
        chk("RND.inv_if_id", {31'd0, h.if_id_stall & h.if_id_flush}, 0);
        chk("RND.inv_id_ex", {31'd0, h.id_ex_stall & h.id_ex_flush}, 0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
